// File: rtl/mu0_bus_arbiter_if.sv
// Avalon-style master port of the MU0 memory arbiter: request fields driven by the
// master, waitrequest/readdata/readdatavalid returned by the arbiter.
interface mu0_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mu0_bus_arbiter.sv
// Two-master round-robin arbiter for the single MU0 memory port, hiding read latency
// behind waitrequest/readdatavalid and counting contention stalls.
module mu0_bus_arbiter #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mu0_bus_arbiter_if.slave  m0,
  mu0_bus_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [15:0]       stall_count
);

  typedef enum logic [1:0] {StIdle, StRdWait, StResetHold} state_e;

  localparam logic [1:0] CntInit = (MEM_LATENCY == 0) ? 2'd0 : 2'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       stall_q, stall_d;

  logic              req0, req1;
  logic              grant_sel;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic [1:0]        stall_inc;
  logic [16:0]       stall_sum;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // On a tie the master that did not win last time gets the port.
  assign grant_sel     = (req0 && req1) ? ~last_grant_q : req1;
  assign sel_write     = grant_sel ? m1.write     : m0.write;
  assign sel_address   = grant_sel ? m1.address   : m0.address;
  assign sel_writedata = grant_sel ? m1.writedata : m0.writedata;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    owner_d          = owner_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    m0.waitrequest   = 1'b1;
    m1.waitrequest   = 1'b1;
    m0.readdatavalid = 1'b0;
    m1.readdatavalid = 1'b0;
    m0.readdata      = mem_readdata;
    m1.readdata      = mem_readdata;
    mem_address      = addr_q;
    mem_writedata    = '0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;

    if (rst) begin
      state_d = StResetHold;
    end else begin
      unique case (state_q)
        // The first cycle after reset already arbitrates like IDLE.
        StIdle, StResetHold: begin
          state_d = StIdle;
          if (req0 || req1) begin
            if (grant_sel) m1.waitrequest = 1'b0;
            else           m0.waitrequest = 1'b0;
            mem_address   = sel_address;
            mem_writedata = sel_writedata;
            mem_write     = sel_write;
            mem_read      = ~sel_write;
            last_grant_d  = grant_sel;
            addr_d        = sel_address;
            if (!sel_write) begin
              if (MEM_LATENCY == 0) begin
                if (grant_sel) m1.readdatavalid = 1'b1;
                else           m0.readdatavalid = 1'b1;
              end else begin
                owner_d = grant_sel;
                cnt_d   = CntInit;
                state_d = StRdWait;
              end
            end
          end
        end
        StRdWait: begin
          if (cnt_q == 2'd0) begin
            if (owner_q) m1.readdatavalid = 1'b1;
            else         m0.readdatavalid = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: state_d = StResetHold;
      endcase
    end
  end

  assign stall_inc = rst ? 2'd0
                         : {1'b0, req0 & m0.waitrequest} + {1'b0, req1 & m1.waitrequest};
  assign stall_sum = {1'b0, stall_q} + {15'd0, stall_inc};
  assign stall_d   = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StResetHold;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      stall_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_mu0_bus_arbiter.sv
// Directed bench: one arbiter per MEM_LATENCY value (0..3) sharing clock, reset and a
// behavioural memory whose read data follows the held memory address.
module tb_mu0_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  m0_rd, m0_wr, m1_rd, m1_wr;
  logic [3:0]  m0_wait, m1_wait, m0_rdv, m1_rdv, mem_rd, mem_wr;
  logic [11:0] m0_addr [4];
  logic [11:0] m1_addr [4];
  logic [11:0] mem_addr [4];
  logic [15:0] m0_wd [4];
  logic [15:0] m1_wd [4];
  logic [15:0] m0_rdata [4];
  logic [15:0] m1_rdata [4];
  logic [15:0] mem_wdata [4];
  logic [15:0] mem_rdata [4];
  logic [15:0] stall [4];

  logic [15:0] mem [4096];
  logic        tb_we;
  logic [11:0] tb_wa;
  logic [15:0] tb_wd;

  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_wa] <= tb_wd;
    for (int i = 0; i < 4; i++) begin
      if (mem_wr[i]) mem[mem_addr[i]] <= mem_wdata[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mu0_bus_arbiter_if #(.ADDR_W(12), .DATA_W(16)) m0_if ();
    mu0_bus_arbiter_if #(.ADDR_W(12), .DATA_W(16)) m1_if ();

    assign m0_if.address   = m0_addr[g];
    assign m0_if.read      = m0_rd[g];
    assign m0_if.write     = m0_wr[g];
    assign m0_if.writedata = m0_wd[g];
    assign m1_if.address   = m1_addr[g];
    assign m1_if.read      = m1_rd[g];
    assign m1_if.write     = m1_wr[g];
    assign m1_if.writedata = m1_wd[g];
    assign m0_wait[g]      = m0_if.waitrequest;
    assign m1_wait[g]      = m1_if.waitrequest;
    assign m0_rdv[g]       = m0_if.readdatavalid;
    assign m1_rdv[g]       = m1_if.readdatavalid;
    assign m0_rdata[g]     = m0_if.readdata;
    assign m1_rdata[g]     = m1_if.readdata;
    assign mem_rdata[g]    = mem[mem_addr[g]];

    mu0_bus_arbiter #(
      .ADDR_W     (12),
      .DATA_W     (16),
      .MEM_LATENCY(g)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .m0           (m0_if),
      .m1           (m1_if),
      .mem_address  (mem_addr[g]),
      .mem_read     (mem_rd[g]),
      .mem_write    (mem_wr[g]),
      .mem_writedata(mem_wdata[g]),
      .mem_readdata (mem_rdata[g]),
      .stall_count  (stall[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int l, input int m, input logic rd, input logic wr,
                       input logic [11:0] a, input logic [15:0] d);
    if (m == 0) begin
      m0_rd[l] = rd; m0_wr[l] = wr; m0_addr[l] = a; m0_wd[l] = d;
    end else begin
      m1_rd[l] = rd; m1_wr[l] = wr; m1_addr[l] = a; m1_wd[l] = d;
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    next();
    tb_we = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int l = 0; l < 4; l++) begin
      set_m(l, 0, 1'b0, 1'b0, 12'h0, 16'h0);
      set_m(l, 1, 1'b0, 1'b0, 12'h0, 16'h0);
    end
    next();
    poke(12'h005, 16'h1234);
    poke(12'h020, 16'hBEEF);
    poke(12'h030, 16'h7777);
    for (int i = 0; i < 4; i++) poke(12'(i), 16'hA000 + 16'(i));

    // Reset values, with a request present that must be ignored
    set_m(1, 0, 1'b1, 1'b0, 12'h005, 16'h0);
    @(negedge clk);
    chk("rst_m0_wait", 32'(m0_wait[1]), 32'h1);
    chk("rst_m1_wait", 32'(m1_wait[1]), 32'h1);
    chk("rst_mem_rd", 32'(mem_rd[1]), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr[1]), 32'h0);
    chk("rst_m0_rdv", 32'(m0_rdv[1]), 32'h0);
    chk("rst_stall", 32'(stall[1]), 32'h0);
    next();

    // Write contention in the first post-reset cycle, latency 1
    set_m(1, 0, 1'b0, 1'b1, 12'h010, 16'hAAAA);
    set_m(1, 1, 1'b0, 1'b1, 12'h011, 16'h5555);
    rst = 1'b0;
    @(negedge clk);
    chk("wc1_m0_wait", 32'(m0_wait[1]), 32'h0);
    chk("wc1_m1_wait", 32'(m1_wait[1]), 32'h1);
    chk("wc1_mem_wr", 32'(mem_wr[1]), 32'h1);
    chk("wc1_addr", 32'(mem_addr[1]), 32'h010);
    chk("wc1_wdata", 32'(mem_wdata[1]), 32'hAAAA);
    next();
    set_m(1, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("wc2_m1_wait", 32'(m1_wait[1]), 32'h0);
    chk("wc2_mem_wr", 32'(mem_wr[1]), 32'h1);
    chk("wc2_addr", 32'(mem_addr[1]), 32'h011);
    chk("wc2_wdata", 32'(mem_wdata[1]), 32'h5555);
    next();
    set_m(1, 1, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("wc_stall", 32'(stall[1]), 32'h1);
    chk("wc_mem010", 32'(mem[12'h010]), 32'hAAAA);
    chk("wc_mem011", 32'(mem[12'h011]), 32'h5555);
    chk("wc_idle_wr", 32'(mem_wr[1]), 32'h0);
    next();

    // Single read, latency 1
    pulse_reset();
    set_m(1, 0, 1'b1, 1'b0, 12'h005, 16'h0);
    @(negedge clk);
    chk("rd1_m0_wait", 32'(m0_wait[1]), 32'h0);
    chk("rd1_mem_rd", 32'(mem_rd[1]), 32'h1);
    chk("rd1_addr", 32'(mem_addr[1]), 32'h005);
    chk("rd1_early_rdv", 32'(m0_rdv[1]), 32'h0);
    next();
    set_m(1, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("rd1_rdv", 32'(m0_rdv[1]), 32'h1);
    chk("rd1_rdata", 32'(m0_rdata[1]), 32'h1234);
    chk("rd1_m1_rdv", 32'(m1_rdv[1]), 32'h0);
    chk("rd1_mem_rd_wait", 32'(mem_rd[1]), 32'h0);
    chk("rd1_stall", 32'(stall[1]), 32'h0);
    next();
    @(negedge clk);
    chk("rd1_rdv_pulse", 32'(m0_rdv[1]), 32'h0);
    next();

    // Read stall, latency 3: m1 reads, m0 writes one cycle later
    set_m(3, 1, 1'b1, 1'b0, 12'h020, 16'h0);
    @(negedge clk);
    chk("rs_m1_wait", 32'(m1_wait[3]), 32'h0);
    chk("rs_mem_rd", 32'(mem_rd[3]), 32'h1);
    chk("rs_addr", 32'(mem_addr[3]), 32'h020);
    next();
    set_m(3, 1, 1'b0, 1'b0, 12'h0, 16'h0);
    set_m(3, 0, 1'b0, 1'b1, 12'h040, 16'h1111);
    @(negedge clk);
    chk("rs1_m0_wait", 32'(m0_wait[3]), 32'h1);
    chk("rs1_m1_rdv", 32'(m1_rdv[3]), 32'h0);
    chk("rs1_mem_rd", 32'(mem_rd[3]), 32'h0);
    chk("rs1_addr_hold", 32'(mem_addr[3]), 32'h020);
    next();
    @(negedge clk);
    chk("rs2_m0_wait", 32'(m0_wait[3]), 32'h1);
    chk("rs2_m1_rdv", 32'(m1_rdv[3]), 32'h0);
    next();
    @(negedge clk);
    chk("rs3_m1_rdv", 32'(m1_rdv[3]), 32'h1);
    chk("rs3_rdata", 32'(m1_rdata[3]), 32'hBEEF);
    chk("rs3_m0_wait", 32'(m0_wait[3]), 32'h1);
    chk("rs3_m0_rdv", 32'(m0_rdv[3]), 32'h0);
    next();
    @(negedge clk);
    chk("rs4_m0_wait", 32'(m0_wait[3]), 32'h0);
    chk("rs4_mem_wr", 32'(mem_wr[3]), 32'h1);
    chk("rs4_addr", 32'(mem_addr[3]), 32'h040);
    chk("rs4_m1_rdv", 32'(m1_rdv[3]), 32'h0);
    next();
    set_m(3, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("rs_stall", 32'(stall[3]), 32'h3);
    chk("rs_mem040", 32'(mem[12'h040]), 32'h1111);
    next();

    // Latency 0: back-to-back reads
    for (int i = 0; i < 4; i++) begin
      set_m(0, 0, 1'b1, 1'b0, 12'(i), 16'h0);
      @(negedge clk);
      chk("l0_m0_wait", 32'(m0_wait[0]), 32'h0);
      chk("l0_rdv", 32'(m0_rdv[0]), 32'h1);
      chk("l0_rdata", 32'(m0_rdata[0]), 32'hA000 + 32'(i));
      next();
    end
    set_m(0, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("l0_rdv_off", 32'(m0_rdv[0]), 32'h0);
    next();

    // Reset mid-read, latency 2
    set_m(2, 0, 1'b1, 1'b0, 12'h030, 16'h0);
    set_m(2, 1, 1'b0, 1'b1, 12'h031, 16'h9999);
    @(negedge clk);
    chk("rm_m0_wait", 32'(m0_wait[2]), 32'h0);
    chk("rm_m1_wait", 32'(m1_wait[2]), 32'h1);
    chk("rm_mem_rd", 32'(mem_rd[2]), 32'h1);
    next();
    set_m(2, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    set_m(2, 1, 1'b0, 1'b0, 12'h0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rm1_rdv", 32'(m0_rdv[2]), 32'h0);
    chk("rm1_stall_pre", 32'(stall[2]), 32'h1);
    next();
    @(negedge clk);
    chk("rm2_rdv", 32'(m0_rdv[2]), 32'h0);
    chk("rm2_stall", 32'(stall[2]), 32'h0);
    chk("rm2_m0_wait", 32'(m0_wait[2]), 32'h1);
    next();
    rst = 1'b0;
    set_m(2, 0, 1'b0, 1'b1, 12'h032, 16'h0101);
    set_m(2, 1, 1'b0, 1'b1, 12'h033, 16'h0202);
    @(negedge clk);
    chk("rm3_rdv", 32'(m0_rdv[2]), 32'h0);
    chk("rm3_tie_m0", 32'(m0_wait[2]), 32'h0);
    chk("rm3_tie_m1", 32'(m1_wait[2]), 32'h1);
    chk("rm3_addr", 32'(mem_addr[2]), 32'h032);
    next();
    set_m(2, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(negedge clk);
    chk("rm4_m1_wait", 32'(m1_wait[2]), 32'h0);
    next();
    set_m(2, 1, 1'b0, 1'b0, 12'h0, 16'h0);

    // Saturation: continuous write contention on latency 1, one stall per cycle
    pulse_reset();
    set_m(1, 0, 1'b0, 1'b1, 12'h100, 16'h0001);
    set_m(1, 1, 1'b0, 1'b1, 12'h101, 16'h0002);
    repeat (100) next();
    @(negedge clk);
    chk("sat_100", 32'(stall[1]), 32'd100);
    next();
    repeat (65433) next();
    @(negedge clk);
    chk("sat_fffe", 32'(stall[1]), 32'hFFFE);
    next();
    @(negedge clk);
    chk("sat_ffff", 32'(stall[1]), 32'hFFFF);
    repeat (4465) next();
    @(negedge clk);
    chk("sat_hold", 32'(stall[1]), 32'hFFFF);
    next();
    set_m(1, 0, 1'b0, 1'b0, 12'h0, 16'h0);
    set_m(1, 1, 1'b0, 1'b0, 12'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
